// File: rtl/ap_txn_profiler.sv
// ap_txn_profiler: ap_ctrl transaction profiler; each completion becomes one {id, latency, interval, iters} record, visible one cycle after done.
// Records queue in a DEPTH-entry FIFO; a completion that meets a full FIFO with no pop that cycle is dropped and counted.

module ap_txn_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_vld = !empty;
    assign pop     = out_vld && out_rdy;
    // A pop frees the head slot this cycle, so a push into a full FIFO is still accepted.
    assign in_rdy  = !full || pop;
    assign push    = in_vld && in_rdy;
    assign out_dat = out_vld ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_dat;
    end
endmodule

module ap_txn_profiler #(
    parameter int CNT_W = 32,
    parameter int ID_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ap_start,
    input  logic                    ap_ready,
    input  logic                    ap_done,
    input  logic                    ap_continue,
    input  logic                    iter_start,
    input  logic                    finish,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [ID_W+3*CNT_W-1:0] rec_data,
    output logic                    busy,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    proto_err,
    output logic                    flush_done
);
    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] latency;
        logic [CNT_W-1:0] interval;
        logic [CNT_W-1:0] iters;
    } rec_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] ts;
    logic [CNT_W-1:0] t0;
    logic             have_prev;
    logic [CNT_W-1:0] interval_r;
    logic [CNT_W-1:0] iters_r;
    logic             ready_seen;
    logic [ID_W-1:0]  id;
    logic             fin_seen;
    logic             flush_r;
    logic             proto_r;
    logic [CNT_W-1:0] drop_r;

    logic             fin;
    logic             done_now;
    logic             start_acc;
    logic             complete;
    logic             ready_now;
    logic [CNT_W-1:0] iters_now;
    logic [CNT_W-1:0] intv_now;
    rec_t             rec_now;
    logic             fifo_in_rdy;

    assign fin       = fin_seen || finish;
    assign done_now  = ap_done && ap_continue;
    assign start_acc = (state == IDLE) && ap_start && !fin;
    assign complete  = done_now && ((state == RUN) || start_acc);
    assign intv_now  = have_prev ? ts - t0 : '0;
    assign ready_now = ((state == RUN) && ready_seen) || ap_ready;
    assign iters_now = (state == RUN) ? sat_inc(iters_r, iter_start)
                                      : {{(CNT_W-1){1'b0}}, iter_start};

    // A start that coincides with done completes in IDLE with zero latency.
    always_comb begin
        rec_now          = '0;
        rec_now.id       = id;
        rec_now.latency  = (state == RUN) ? ts - t0 : '0;
        rec_now.interval = (state == RUN) ? interval_r : intv_now;
        rec_now.iters    = iters_now;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_acc && !done_now) state_nxt = RUN;
            RUN:  if (done_now)               state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ts         <= '0;
            t0         <= '0;
            have_prev  <= 1'b0;
            interval_r <= '0;
            iters_r    <= '0;
            ready_seen <= 1'b0;
            id         <= '0;
            fin_seen   <= 1'b0;
            flush_r    <= 1'b0;
            proto_r    <= 1'b0;
            drop_r     <= '0;
        end else begin
            state    <= state_nxt;
            ts       <= ts + 1'b1;
            fin_seen <= fin;
            flush_r  <= flush_done;
            if (start_acc) begin
                t0         <= ts;
                have_prev  <= 1'b1;
                interval_r <= intv_now;
            end
            if ((state == RUN) || start_acc) begin
                iters_r    <= iters_now;
                ready_seen <= ready_now;
            end
            if (complete) begin
                id <= id + 1'b1;
                if (!ready_now) proto_r <= 1'b1;
                if (!fifo_in_rdy) drop_r <= sat_inc(drop_r, 1'b1);
            end
        end
    end

    ap_txn_fifo #(
        .WIDTH (ID_W + 3*CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .in_vld  (complete),
        .in_rdy  (fifo_in_rdy),
        .in_dat  (rec_now),
        .out_vld (rec_valid),
        .out_rdy (rec_ready),
        .out_dat (rec_data)
    );

    assign busy       = (state == RUN);
    assign drop_cnt   = drop_r;
    assign proto_err  = proto_r;
    assign flush_done = flush_r || (fin && (state == IDLE) && !rec_valid);
endmodule

// File: tb/tb_ap_txn_profiler.sv
// Directed bench for ap_txn_profiler (DEPTH=4): absolute-cycle stimulus with hand-computed records.
module tb_ap_txn_profiler;
    logic         clock = 1'b0;
    logic         reset;
    logic         ap_start, ap_ready, ap_done, ap_continue, iter_start, finish;
    logic         rec_valid, rec_ready;
    logic [111:0] rec_data;
    logic         busy;
    logic [31:0]  drop_cnt;
    logic         proto_err, flush_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    ap_txn_profiler #(.CNT_W(32), .ID_W(16), .DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .iter_start  (iter_start),
        .finish      (finish),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_data    (rec_data),
        .busy        (busy),
        .drop_cnt    (drop_cnt),
        .proto_err   (proto_err),
        .flush_done  (flush_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic at(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [127:0] rec(input int id, input int lat, input int intv, input int it);
        return {16'h0, id[15:0], lat, intv, it};
    endfunction

    initial begin
        reset = 1'b1; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1;
        iter_start = 0; finish = 0; rec_ready = 1;
        repeat (2) @(posedge clock);
        #1;
        cyc = 0; reset = 1'b0;
        #1;
        chk("rst_busy", 128'(busy), 0);
        chk("rst_valid", 128'(rec_valid), 0);
        chk("rst_data", 128'(rec_data), 0);
        chk("rst_drop", 128'(drop_cnt), 0);
        chk("rst_perr", 128'(proto_err), 0);
        chk("rst_flush", 128'(flush_done), 0);

        // single transaction, then back-to-back
        at(5);  ap_start = 1; ap_ready = 1;
        at(6);  ap_start = 0; ap_ready = 0; iter_start = 1; #1;
        chk("t1_busy_start", 128'(busy), 1);
        at(14); iter_start = 0; ap_done = 1; #1;
        chk("t1_busy_end", 128'(busy), 1);
        chk("t1_no_rec_yet", 128'(rec_valid), 0);
        at(15); ap_done = 0; ap_start = 1; ap_ready = 1; #1;
        chk("t1_busy_off", 128'(busy), 0);
        chk("t1_valid", 128'(rec_valid), 1);
        chk("t1_rec", 128'(rec_data), rec(0, 9, 0, 8));
        at(16); ap_start = 0; ap_ready = 0; #1;
        chk("t2_busy", 128'(busy), 1);
        chk("t1_popped", 128'(rec_valid), 0);
        at(20); ap_done = 1;
        at(21); ap_done = 0; #1;
        chk("t2_valid", 128'(rec_valid), 1);
        chk("t2_rec", 128'(rec_data), rec(1, 5, 10, 0));

        // done held while ap_continue low
        at(25); ap_start = 1; ap_ready = 1;
        at(26); ap_start = 0; ap_ready = 0;
        at(30); iter_start = 1;
        at(33); iter_start = 0;
        at(34); ap_done = 1; ap_continue = 0;
        at(36); #1;
        chk("t3_busy_held", 128'(busy), 1);
        chk("t3_no_rec", 128'(rec_valid), 0);
        at(37); ap_continue = 1;
        at(38); ap_done = 0; #1;
        chk("t3_rec", 128'(rec_data), rec(2, 12, 10, 3));
        at(39); #1;
        chk("t3_one_rec", 128'(rec_valid), 0);

        // no ap_ready anywhere
        at(40); ap_start = 1;
        at(41); ap_start = 0;
        at(42); ap_done = 1; #1;
        chk("t5_perr_before", 128'(proto_err), 0);
        at(43); ap_done = 0; #1;
        chk("t5_perr_set", 128'(proto_err), 1);
        chk("t5_rec", 128'(rec_data), rec(3, 2, 15, 0));

        // start and done in the same cycle
        at(45); ap_start = 1; ap_ready = 1; ap_done = 1; iter_start = 1;
        at(46); ap_start = 0; ap_ready = 0; ap_done = 0; iter_start = 0; #1;
        chk("t0_imm_busy", 128'(busy), 0);
        chk("t0_imm_rec", 128'(rec_data), rec(4, 0, 5, 1));
        chk("t5_perr_sticky", 128'(proto_err), 1);

        // overflow: six completions into four slots
        at(49); rec_ready = 0;
        for (int k = 0; k < 6; k++) begin
            at(50 + 2*k); ap_done = 0; ap_start = 1; ap_ready = 1;
            at(51 + 2*k); ap_start = 0; ap_ready = 0; ap_done = 1;
        end
        at(62); ap_done = 0; #1;
        chk("t4_drop", 128'(drop_cnt), 2);
        chk("t4_head_valid", 128'(rec_valid), 1);
        chk("t4_head_stable", 128'(rec_data), rec(5, 1, 5, 0));
        at(63); rec_ready = 1;
        for (int k = 0; k < 4; k++) begin
            at(63 + k); #1;
            chk("t4_drain", 128'(rec_data), rec(5 + k, 1, (k == 0) ? 5 : 2, 0));
        end
        at(67); #1;
        chk("t4_empty", 128'(rec_valid), 0);
        at(68); ap_start = 1; ap_ready = 1;
        at(69); ap_start = 0; ap_ready = 0;
        at(70); ap_done = 1;
        at(71); ap_done = 0; #1;
        chk("t4_next_id", 128'(rec_data), rec(11, 2, 8, 0));

        // push into a full FIFO in the same cycle as a pop
        at(72); rec_ready = 0;
        for (int k = 0; k < 5; k++) begin
            at(74 + 2*k); ap_done = 0; rec_ready = 0; ap_start = 1; ap_ready = 1;
            at(75 + 2*k); ap_start = 0; ap_ready = 0; ap_done = 1; rec_ready = (k == 4);
        end
        at(84); ap_done = 0; rec_ready = 0; #1;
        chk("full_pp_drop", 128'(drop_cnt), 2);
        chk("full_pp_head", 128'(rec_data), rec(13, 1, 2, 0));
        at(85); rec_ready = 1;
        for (int k = 0; k < 4; k++) begin
            at(85 + k); #1;
            chk("full_pp_drain", 128'(rec_data), rec(13 + k, 1, 2, 0));
        end
        at(89); #1;
        chk("full_pp_empty", 128'(rec_valid), 0);

        // finish mid-RUN
        at(90); ap_start = 1; ap_ready = 1;
        at(91); ap_start = 0; ap_ready = 0;
        at(92); finish = 1; #1;
        chk("fin_flush_run", 128'(flush_done), 0);
        at(93); finish = 0;
        at(94); ap_done = 1;
        at(95); ap_done = 0; rec_ready = 0; ap_start = 1; ap_ready = 1; #1;
        chk("fin_rec", 128'(rec_data), rec(17, 4, 8, 0));
        chk("fin_flush_notempty", 128'(flush_done), 0);
        at(96); ap_start = 0; ap_ready = 0; #1;
        chk("fin_start_ignored", 128'(busy), 0);
        at(97); rec_ready = 1; #1;
        chk("fin_flush_popcyc", 128'(flush_done), 0);
        at(98); rec_ready = 0; #1;
        chk("fin_flush_done", 128'(flush_done), 1);
        chk("fin_empty", 128'(rec_valid), 0);

        // reset clears sticky state, then reset during RUN
        at(101); reset = 1;
        at(102); reset = 0; #1;
        chk("rst2_drop", 128'(drop_cnt), 0);
        chk("rst2_perr", 128'(proto_err), 0);
        chk("rst2_flush", 128'(flush_done), 0);
        at(104); ap_start = 1; ap_ready = 1;
        at(105); ap_start = 0; ap_ready = 0; #1;
        chk("rrun_busy", 128'(busy), 1);
        at(106); reset = 1;
        at(107); reset = 0; #1;
        chk("rrun_busy_clr", 128'(busy), 0);
        chk("rrun_valid", 128'(rec_valid), 0);
        at(108); ap_done = 1;
        at(109); ap_done = 0; #1;
        chk("rrun_no_rec", 128'(rec_valid), 0);
        chk("rrun_perr", 128'(proto_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ap_txn_profiler.md
# ap_txn_profiler

Synthesizable transaction profiler that sits directly downstream of an HLS block's `ap_ctrl` handshake and loop-iteration strobe, in the same position the simulation dataflow monitors occupy. It timestamps each non-dataflow transaction and measures start-to-done latency, start-to-start interval and loop iteration count. Each completed transaction becomes one record in an internal FIFO, which is drained over a valid/ready stream. It gives on-chip (post-synthesis) runs the same per-transaction status the CSV dumpers provide in C/RTL co-simulation.

## Interface
- `CNT_W`, default 32: width of the latency, interval, iteration and drop counters. All of these counters saturate at all-ones.
- `ID_W`, default 16: width of the transaction id. The id wraps modulo 2^ID_W.
- `DEPTH`, default 8: record FIFO depth. Must be a power of 2 and ≥ 2.
- `clock` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ap_start` in 1: monitored block's start.
- `ap_ready` in 1: monitored block's ready.
- `ap_done` in 1: monitored block's done. Held high until `ap_continue`.
- `ap_continue` in 1: tie to 1 when the monitored block has no continue.
- `iter_start` in 1: loop iteration-start strobe (pipeline stage0 enable and not blocked).
- `finish` in 1: end of test. Once seen, it is treated as sticky internally.
- `rec_valid` out 1: record available at FIFO head.
- `rec_ready` in 1: consumer accepts the record.
- `rec_data` out ID_W+3*CNT_W: record, packed as {id, latency, interval, iters}, with id in the MSBs.
- `busy` out 1: a transaction is in progress.
- `drop_cnt` out CNT_W: number of records lost to a full FIFO.
- `proto_err` out 1: sticky protocol-violation flag.
- `flush_done` out 1: sticky; finish seen, idle and FIFO empty.

## Operation
- **Free-running timestamp** `ts`: counts +1 per cycle from reset and wraps. All differences are computed modulo 2^CNT_W and then saturated.
- **States:** IDLE, RUN.
- **IDLE → RUN:**
  - Condition: `ap_start`=1 and finish not seen. Call this cycle t0.
  - Latch t0.
  - Set `iters` to `iter_start` sampled at t0.
  - Set `ready_seen` to `ap_ready` sampled at t0.
  - If `ap_done && ap_continue` is also high at t0, complete immediately with latency 0 and stay in IDLE.
- **In RUN:**
  - `iters` += `iter_start`.
  - `ready_seen` |= `ap_ready`.
  - Further `ap_start` pulses are ignored.
- **RUN → IDLE:**
  - Condition: `ap_done && ap_continue` at cycle t1.
  - latency = t1 − t0.
  - `ap_done` high with `ap_continue` low does not complete the transaction; latency keeps growing until `ap_continue` rises.
- **Interval:** t0 minus the previous transaction's t0. It is 0 for the first transaction after reset.
- **id:** increments on every completion, whether the record is stored or dropped.
- **proto_err:** set if a completion occurs with `ready_seen`=0, counting `ap_ready` in the completion cycle itself. The record is still produced. Cleared only by reset.
- **FIFO behaviour:**
  - The record is pushed at the edge ending t1.
  - If the FIFO is full and no pop happens in the same cycle, the record is dropped and `drop_cnt` += 1.
  - Push and pop in the same cycle while full: the push is accepted.
  - Records are delivered in completion order.
- **Stream:** `rec_data` is the FIFO head. It is stable while `rec_valid && !rec_ready`. A pop occurs when `rec_valid && rec_ready`.
- **finish:**
  - New starts are ignored from the cycle finish is first seen.
  - A transaction already in RUN runs to completion.
  - `flush_done` rises on the first cycle with finish seen, IDLE and FIFO empty.

## Timing
- **Reset values** (applied on the edge where `reset`=1): state IDLE, `ts`=0, id=0, FIFO empty, `rec_valid`=0, `rec_data`=0, `busy`=0, `drop_cnt`=0, `proto_err`=0, `flush_done`=0, finish-seen=0.
- **Reset mid-RUN:** the transaction is abandoned with no record, and all state is cleared on the next cycle.
- **busy:** registered; high from t0+1 through t1 inclusive.
- **Record latency:** `rec_valid` goes high at t1+1 when the FIFO was empty. Otherwise the record is visible once all earlier records have been popped.
- **Throughput:** one pop per cycle sustained. The FIFO holds DEPTH records.
- **Back-to-back transactions:** a new t0 may occur at t1+1. A start in the same cycle as t1 is not accepted, because the monitored block is busy.

## Test plan
1. **Single transaction.** Stimulus: reset de-asserted at cycle 0; `ap_start`/`ap_ready` at cycle 5; `iter_start` high during cycles 6–13; `ap_done`=`ap_continue`=1 at cycle 14; `rec_ready`=1. Required response: `rec_valid` at cycle 15 with {id 0, latency 9, interval 0, iters 8}; `busy` high during cycles 6–14.
2. **Back-to-back transaction.** Stimulus: second start at cycle 15, done at cycle 20, no `iter_start`. Required response: record {1, 5, 10, 0}.
3. **Held ap_continue.** Stimulus: `ap_done` rises at cycle 14 with `ap_continue` low until cycle 17. Required response: latency 12; exactly one record.
4. **FIFO overflow.** Stimulus: DEPTH=4, `rec_ready`=0, six transactions completed; then `rec_ready`=1. Required response: records with ids 0,1,2,3 drain in order; `drop_cnt`=2; the next transaction is stored with id 6.
5. **Protocol error.** Stimulus: a completion with no `ap_ready` anywhere in the transaction. Required response: `proto_err`=1 from the next cycle and stays 1 through later clean transactions; the record is still emitted.
6. **finish and reset.** Stimulus: `finish` asserted mid-RUN, then a further `ap_start`. Required response: the running transaction still produces its record; the later start is ignored; `flush_done`=1 the cycle after the last pop. Separately, `reset` during RUN gives `busy`=0, `rec_valid`=0 and no record.
